// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, counter sizing
// helper and the quotient value reported for a zero divisor.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bits needed to count 0 .. value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits = bits + 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    // Quotient reported when the divisor is zero (sliced to WIDTH by the user).
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_trial_subtractor.sv
// Combinational W-bit a - b with borrow-out. Shared between the divider's
// trial subtraction and the ALU subtract path.
module div_trial_subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] full;

    // One extra bit on the left captures the borrow out of the MSB.
    assign full   = {1'b0, a} - {1'b0, b};
    assign diff   = full[W-1:0];
    assign borrow = full[W];

endmodule

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/done handshake; quotient, remainder and divide-by-zero flag are
// held after done until the next accepted start.
module shift_subtract_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W      = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             take;
    logic             divisor_zero;

    assign divisor_zero = (divisor == '0);

    // Partial remainder shifted left with the next dividend bit brought in.
    assign rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

    div_trial_subtractor #(
        .W (WIDTH + 1)
    ) u_trial (
        .a      (rem_shift),
        .b      ({1'b0, dvsr_q}),
        .diff   (trial),
        .borrow (borrow)
    );

    // A bit shifted out of the remainder MSB means the shifted value already
    // exceeds any divisor, so the subtraction is taken regardless of borrow.
    // With the remainder kept below the divisor that bit is always zero.
    assign take = ~borrow | rem_q[WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero divisor skips RUN, DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = divisor_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (count_q == LAST_COUNT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded purely from registered state.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next-state: load on accept, one restoring step per RUN cycle.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        dbz_d   = dbz_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvsr_d  = divisor;
                    count_d = '0;
                    if (divisor_zero) begin
                        quo_d = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        rem_d = {1'b0, dividend};
                        dbz_d = 1'b1;
                    end else begin
                        quo_d = dividend;
                        rem_d = '0;
                        dbz_d = 1'b0;
                    end
                end
            end
            RUN: begin
                rem_d   = take ? trial : rem_shift;
                quo_d   = {quo_q[WIDTH-2:0], take};
                count_d = count_q + 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            dbz_q   <= 1'b0;
            count_q <= '0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            dbz_q   <= dbz_d;
            count_q <= count_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_subtract_divider.sv
// Scoreboard bench for shift_subtract_divider (WIDTH=8): the driver pushes
// the expected result at each accepted start, a negedge monitor pops and
// compares whenever done is high.
module tb_shift_subtract_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dones_seen = 0;
    int   dones_expected = 0;

    shift_subtract_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            dones_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_quotient", quotient, e.q);
                chk("sb_remainder", remainder, e.r);
                chk("sb_div_by_zero", div_by_zero, e.z);
            end
        end
    end

    function automatic exp_t ref_div(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Called at the negedge following the start edge; returns cycles until
    // done (1 = the cycle right after the start edge) and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_n, output bit got);
        lat = 1;
        busy_n = 0;
        got = 1'b0;
        while (lat <= 40) begin
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Full transaction; returns at the negedge of the DONE cycle.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er,
                           input logic ez, input int hold_cycles);
        int lat;
        int busy_n;
        bit got;
        exp_q.push_back('{q: eq, r: er, z: ez});
        dones_expected++;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n, got);
        if (got) begin
            chk("latency", lat, (b == 8'd0) ? 32'd1 : 32'd9);
            chk("busy_cycles", busy_n, (b == 8'd0) ? 32'd0 : 32'd8);
        end
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            chk("hold_quotient", quotient, eq);
            chk("hold_remainder", remainder, er);
            chk("hold_div_by_zero", div_by_zero, ez);
            chk("hold_done_low", done, 1'b0);
        end
    endtask

    initial begin
        int lat;
        int busy_n;
        bit got;
        exp_t e;
        logic [7:0] a;
        logic [7:0] b;

        rst = 1'b1;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_quotient", quotient, 8'd0);
        chk("rst_remainder", remainder, 8'd0);
        chk("rst_div_by_zero", div_by_zero, 1'b0);
        rst = 1'b0;

        // 1. basic division
        run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0);

        // 2. extremes and dividend smaller than divisor, with hold checks
        run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 3);
        run_div(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 3);

        // 3. zero divisor
        run_div(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 2);

        // 4. starts during RUN and DONE are ignored
        exp_q.push_back('{q: 8'd15, r: 8'd0, z: 1'b0});
        dones_expected++;
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd60;
        divisor = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd9;
        divisor = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, busy_n, got);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", busy, 1'b0);
        repeat (12) @(negedge clk);
        chk("ignored_start_idle_busy", busy, 1'b0);
        chk("ignored_start_quotient", quotient, 8'd15);

        // 5. reset mid-run discards the result
        @(negedge clk);
        start = 1'b1;
        dividend = 8'd123;
        divisor = 8'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_quotient", quotient, 8'd0);
        chk("midrst_remainder", remainder, 8'd0);
        chk("midrst_div_by_zero", div_by_zero, 1'b0);
        repeat (12) @(negedge clk);
        chk("midrst_stays_idle", busy, 1'b0);
        run_div(8'd123, 8'd10, 8'd12, 8'd3, 1'b0, 0);

        // 6. back-to-back start in the IDLE cycle after done
        run_div(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 0);

        // Random sweep against the reference model
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            e = ref_div(a, b);
            run_div(a, b, e.q, e.r, e.z, 0);
            if (b != 8'd0) begin
                chk("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                chk("rem_below_divisor", (remainder < b) ? 32'd1 : 32'd0, 32'd1);
            end
        end

        repeat (4) @(negedge clk);
        chk("done_count", dones_seen, dones_expected);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
